int_to_float_sequential: RTL

INT_TO_FLOAT_SEQUENTIAL -- requirements
Module: int_to_float_sequential

---
 rtl/int_to_float_sequential.sv | 121 ++++++++++++
 1 files changed

// File: rtl/int_to_float_sequential.sv
// Sequential 32-bit integer (signed or unsigned) to IEEE-754 single-precision
// converter: one-bit-per-cycle normalisation followed by a round-to-nearest-even step.
module int_to_float_sequential (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_mode,
  input  logic [31:0] int_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        sign, sign_next;
  logic [31:0] mag, mag_next;
  logic [7:0]  expo, expo_next;
  logic        zero, zero_next;
  logic        done_next;
  logic [31:0] result_next;
  logic        inexact_next;

  logic [22:0] frac;
  logic [22:0] frac_rnd;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic        carry;
  logic        neg_in;

  // Round-to-nearest-even datapath on the normalised magnitude
  always_comb begin
    frac             = mag[30:8];
    guard            = mag[7];
    sticky           = |mag[6:0];
    round_up         = guard & (sticky | frac[0]);
    {carry, frac_rnd} = {1'b0, frac} + {23'd0, round_up};
    neg_in           = signed_mode & int_in[31];
  end

  // Next-state and datapath control
  always_comb begin
    state_next   = state;
    sign_next    = sign;
    mag_next     = mag;
    expo_next    = expo;
    zero_next    = zero;
    done_next    = 1'b0;
    result_next  = result;
    inexact_next = inexact;
    case (state)
      IDLE: begin
        if (start) begin
          sign_next  = neg_in;
          mag_next   = neg_in ? (32'd0 - int_in) : int_in;
          expo_next  = 8'd158;
          zero_next  = (int_in == 32'd0);
          state_next = NORM;
        end else begin
          state_next = IDLE;
        end
      end
      NORM: begin
        // A zero operand is treated as already normalised so it takes two cycles.
        if (zero || mag[31]) begin
          state_next = ROUND;
        end else begin
          mag_next  = {mag[30:0], 1'b0};
          expo_next = expo - 8'd1;
        end
      end
      ROUND: begin
        if (zero) begin
          result_next  = 32'h0000_0000;
          inexact_next = 1'b0;
        end else begin
          result_next  = {sign, expo + {7'd0, carry}, frac_rnd};
          inexact_next = guard | sticky;
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sign    <= 1'b0;
      mag     <= 32'd0;
      expo    <= 8'd0;
      zero    <= 1'b0;
      done    <= 1'b0;
      result  <= 32'd0;
      inexact <= 1'b0;
    end else begin
      state   <= state_next;
      sign    <= sign_next;
      mag     <= mag_next;
      expo    <= expo_next;
      zero    <= zero_next;
      done    <= done_next;
      result  <= result_next;
      inexact <= inexact_next;
    end
  end

  assign busy = (state != IDLE);

endmodule
